// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - Clocked register bank: one write port, two registered read ports, sequential clear engine
//
// Parameters : WIDTH (entry width), AW (address width, DEPTH = 2**AW), RST_VAL (reset value)
// Ports      : clk, rst (async, active-high)
//              we, waddr, wdata       - write port, used only while idle
//              raddr_a, raddr_b       - read addresses, sampled every edge
//              clr                    - one-cycle pulse that starts the clear of all entries
//              rdata_a, rdata_b       - registered read data
//              busy                   - high while the clear engine runs
// Config     : REGFILE_BYPASS_EN - forward accepted write data to a read port addressing the same entry

module reg_bank #(
  parameter int               WIDTH   = 8,
  parameter int               AW      = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  input  logic             clr,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             busy
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [AW-1:0]    r_ptr;
  logic [AW-1:0]    w_ptr_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata_a;
  logic [WIDTH-1:0] r_rdata_b;
  logic             w_wr_accept;
  logic             w_clr_active;

  // A clr request takes priority over a same-cycle write; writes are
  // only accepted while idle with no clear being requested.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_wr_accept  = 1'b0;
    w_clr_active = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr) begin
          w_state_next = S_CLEAR;
          w_ptr_next   = '0;
        end else begin
          w_wr_accept = we;
        end
      end
      S_CLEAR: begin
        w_clr_active = 1'b1;
        if (r_ptr == LAST_ADDR) begin
          w_state_next = S_IDLE;
          w_ptr_next   = '0;
        end else begin
          w_ptr_next = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // The clear writes zero, not RST_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RST_VAL;
      end
    end else if (w_clr_active) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_accept) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Reads sample the pre-edge contents in every state; with forwarding
  // enabled an accepted write to the same address overrides that value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_a <= RST_VAL;
      r_rdata_b <= RST_VAL;
    end else begin
`ifdef REGFILE_BYPASS_EN
      r_rdata_a <= (w_wr_accept && (waddr == raddr_a)) ? wdata : r_mem[raddr_a];
      r_rdata_b <= (w_wr_accept && (waddr == raddr_b)) ? wdata : r_mem[raddr_b];
`else
      r_rdata_a <= r_mem[raddr_a];
      r_rdata_b <= r_mem[raddr_b];
`endif
    end
  end

  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;
  assign busy    = (r_state == S_CLEAR);

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - Self-checking bench for reg_bank: directed table, clear/reset sequences, random vs model

module tb_reg_bank;

  localparam int         WIDTH = 8;
  localparam int         AW    = 3;
  localparam int         DEPTH = 8;
  localparam logic [7:0] RV    = 8'hA5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic       clr;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       busy;

  int tests;
  int fails;

  reg_bank #(.WIDTH(WIDTH), .AW(AW), .RST_VAL(RV)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .clr     (clr),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: array contents plus the number of clear cycles still owed.
  logic [7:0] m_mem [DEPTH];
  int         m_busy_left;
  logic [7:0] m_ea;
  logic [7:0] m_eb;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = RV;
    m_busy_left = 0;
    m_ea = RV;
    m_eb = RV;
  endtask

  task automatic model_edge();
    m_ea = m_mem[raddr_a];
    m_eb = m_mem[raddr_b];
    if (m_busy_left > 0) begin
      m_mem[DEPTH - m_busy_left] = 8'h00;
      m_busy_left = m_busy_left - 1;
    end else if (clr) begin
      m_busy_left = DEPTH;
    end else if (we) begin
      m_mem[waddr] = wdata;
      if (BYP && waddr == raddr_a) m_ea = wdata;
      if (BYP && waddr == raddr_b) m_eb = wdata;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; clr = 1'b0; raddr_a = '0; raddr_b = '0;
  endtask

  task automatic read_all(input string name, input logic [7:0] exp);
    we = 1'b0; clr = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      raddr_a = 3'(a);
      raddr_b = 3'(DEPTH - 1 - a);
      tick();
      check8(name, rdata_a, exp);
      check8(name, rdata_b, exp);
    end
  endtask

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t vt [7];
  int   busy_cnt;

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    model_reset();

    vt[0] = '{1'b1, 3'd5, 8'h3C, 3'd0, 3'd1, RV,    RV};
    vt[1] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 8'h3C, 8'h3C};
    vt[2] = '{1'b1, 3'd2, 8'h11, 3'd3, 3'd4, RV,    RV};
    vt[3] = '{1'b1, 3'd2, 8'h77, 3'd2, 3'd5, BYP ? 8'h77 : 8'h11, 8'h3C};
    vt[4] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 8'h77, 8'h77};
    vt[5] = '{1'b1, 3'd6, 8'hC3, 3'd7, 3'd6, RV,    BYP ? 8'hC3 : RV};
    vt[6] = '{1'b0, 3'd0, 8'h00, 3'd6, 3'd6, 8'hC3, 8'hC3};

    // Power-on reset, checked before any clock edge.
    rst = 1'b1;
    #2;
    check8("por_rdata_a", rdata_a, RV);
    check8("por_rdata_b", rdata_b, RV);
    check1("por_busy", busy, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Directed table: write/read latency and same-cycle collision.
    for (int i = 0; i < 7; i++) begin
      we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
      raddr_a = vt[i].ra; raddr_b = vt[i].rb; clr = 1'b0;
      tick();
      check8($sformatf("vec%0d_rdata_a", i), rdata_a, vt[i].ea);
      check8($sformatf("vec%0d_rdata_b", i), rdata_b, vt[i].eb);
      check1($sformatf("vec%0d_busy", i), busy, 1'b0);
    end

    // Mid-cycle reset with no clock edge.
    idle_inputs();
    #3 rst = 1'b1;
    #1;
    check8("midrst_rdata_a", rdata_a, RV);
    check8("midrst_rdata_b", rdata_b, RV);
    check1("midrst_busy", busy, 1'b0);
    #1 rst = 1'b0;
    model_reset();
    read_all("after_rst_read", RV);

    // Fill with FF, then clr colliding with a write to address 1.
    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b1; waddr = 3'(a); wdata = 8'hFF;
      tick();
    end
    raddr_a = 3'd7; raddr_b = 3'd1;
    we = 1'b1; waddr = 3'd1; wdata = 8'h42; clr = 1'b1;
    tick();                                   // edge n
    check1("clr_busy_rise", busy, 1'b1);
    check8("clr_collide_no_fwd", rdata_b, 8'hFF);
    busy_cnt = busy ? 1 : 0;
    clr = 1'b0; waddr = 3'd0; wdata = 8'h5A;  // writes during busy must be dropped
    for (int i = 1; i <= 20 && busy; i++) begin
      clr = (i == 3);
      tick();                                 // edge n+i
      if (busy) busy_cnt++;
      if (i == 1) check8("clr_collide_dropped", rdata_b, 8'hFF);
      if (i == 7) check8("clr_addr7_before", rdata_a, 8'hFF);
    end
    check1("clr_busy_fall", busy, 1'b0);
    tests++;
    if (busy_cnt != DEPTH) begin
      fails++;
      $display("FAIL clr_busy_len: got %0d cycles expected %0d", busy_cnt, DEPTH);
    end
    we = 1'b0; clr = 1'b0;
    tick();
    check8("clr_addr7_after", rdata_a, 8'h00);
    read_all("after_clr_read", 8'h00);

    // Reset in the middle of a clear.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check1("midclr_busy_before", busy, 1'b1);
    #3 rst = 1'b1;
    #1;
    check1("midclr_rst_busy", busy, 1'b0);
    check8("midclr_rst_rdata_a", rdata_a, RV);
    #1 rst = 1'b0;
    model_reset();
    read_all("midclr_rst_read", RV);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 3'($urandom_range(0, 7));
      wdata   = 8'($urandom);
      raddr_a = 3'($urandom_range(0, 7));
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      clr     = ($urandom_range(0, 15) == 0);
      tick();
      check8("rnd_rdata_a", rdata_a, m_ea);
      check8("rnd_rdata_b", rdata_b, m_eb);
      check1("rnd_busy", busy, m_busy_left > 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
